obs_compare: RTL and testbench
==============================

OBS_COMPARE -- requirements
Module: obs_compare

Interface
REQ-001 Parameter DATA_W, default 64, width of one retire observation word.
REQ-002 Parameter DEPTH, default 16, entries per core buffer (power of two, >=2).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 obs_1_valid_i  input  1  core 1 retire observation strobe, one word per cycle.
REQ-006 obs_1_data_i  input  DATA_W  core 1 observation word.
REQ-007 obs_2_valid_i  input  1  core 2 retire observation strobe.
REQ-008 obs_2_data_i  input  DATA_W  core 2 observation word.
REQ-009 finished_i  input  1  run-complete flag from fetch/retire control; level, sticky once high.
REQ-010 done_o  output  1  comparison complete, sticky.
REQ-011 mismatch_o  output  1  data mismatch found, sticky.
REQ-012 mismatch_index_o  output  32  index (0-based) of first mismatching pair.
REQ-013 len_mismatch_o  output  1  traces differ in length at drain end, sticky.
REQ-014 overflow_o  output  1  observation dropped on full buffer, sticky.
REQ-015 pair_count_o  output  32  number of pairs compared so far.

Function
REQ-016 Two independent FIFOs, one per core, DEPTH entries each, DATA_W wide.
REQ-017 States: RUN, DRAIN, DONE; reset enters RUN.
REQ-018 RUN: obs_N_valid_i pushes obs_N_data_i into FIFO N.
REQ-019 Pushed word is poppable no earlier than the cycle after the push; no bypass to the comparator.
REQ-020 Compare cycle: both FIFOs non-empty (registered occupancy); pop both heads, compare for equality, pair_count_o increments by 1 on the next edge.
REQ-021 First unequal pair: mismatch_o set and mismatch_index_o loaded with pre-increment pair_count_o, on the next edge.
REQ-022 Later mismatches do not change mismatch_index_o.
REQ-023 Push to full FIFO is accepted if that FIFO pops in the same cycle; otherwise the word is dropped and overflow_o set.
REQ-024 Occupancy counters are log2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.
REQ-025 pair_count_o saturates at 32'hFFFF_FFFF.
REQ-026 RUN -> DRAIN on first cycle finished_i=1; pushes in that cycle are still accepted.
REQ-027 DRAIN: obs_N_valid_i ignored (no push, no overflow); compare cycles continue.
REQ-028 DRAIN -> DONE when at least one FIFO empty; if the other is non-empty, len_mismatch_o set on the same edge.
REQ-029 DONE: done_o=1; no pushes, pops or flag changes until reset; finished_i ignored.
REQ-030 Simultaneous finished_i rising and compare cycle: compare proceeds normally.
REQ-031 done_o never asserts while state is RUN.

Reset
REQ-032 rst_i=1 at an edge: state=RUN, both FIFOs empty, pointers 0, all outputs 0, mismatch_index_o=0.
REQ-033 Reset mid-RUN or mid-DRAIN discards buffered words; no flag survives reset.
REQ-034 Observation strobes during a reset cycle are not pushed.

Verification
REQ-035 Identical streams: 10 words 1..10 both cores, same cycles, then finished_i -> pair_count_o=10, done_o=1, all error flags 0.
REQ-036 Skewed streams: core 2 lags 5 cycles, words equal, 8 each -> pair_count_o=8, no mismatch, no overflow.
REQ-037 Data mismatch: pairs 0..5 equal, pair 3 core 2 word XOR 1, pair 5 also differs -> mismatch_o=1, mismatch_index_o=3.
REQ-038 Length mismatch: core 1 sends 6, core 2 sends 4, finished_i -> pair_count_o=4, len_mismatch_o=1, done_o=1.
REQ-039 Overflow: DEPTH=16, core 1 sends 17 words, core 2 silent -> overflow_o=1 after 17th push, pair_count_o=0.
REQ-040 Reset mid-DRAIN with 3 words buffered -> next cycle all outputs 0; fresh 2-word identical run -> pair_count_o=2, done_o=1.

Source files
------------

// File: rtl/obs_compare.sv
// Lockstep retire-trace comparator: buffers two cores' observation
// streams and compares them pairwise, flagging data/length/overflow errors.
module obs_compare #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              obs_1_valid_i,
  input  logic [DATA_W-1:0] obs_1_data_i,
  input  logic              obs_2_valid_i,
  input  logic [DATA_W-1:0] obs_2_data_i,
  input  logic              finished_i,
  output logic              done_o,
  output logic              mismatch_o,
  output logic [31:0]       mismatch_index_o,
  output logic              len_mismatch_o,
  output logic              overflow_o,
  output logic [31:0]       pair_count_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;
  logic   len_set;

  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];
  logic [AW-1:0]     rd1, wr1, rd2, wr2;
  logic [AW:0]       cnt1, cnt2;

  logic empty1, empty2, full1, full2;
  logic cmp, push1, push2, drop1, drop2;

  assign empty1 = (cnt1 == '0);
  assign empty2 = (cnt2 == '0);
  assign full1  = (cnt1 == (AW+1)'(DEPTH));
  assign full2  = (cnt2 == (AW+1)'(DEPTH));

  // Occupancy is registered, so a word pushed this cycle is never compared.
  assign cmp = (state != DONE) && !empty1 && !empty2;

  assign push1 = (state == RUN) && obs_1_valid_i && (!full1 || cmp);
  assign push2 = (state == RUN) && obs_2_valid_i && (!full2 || cmp);
  assign drop1 = (state == RUN) && obs_1_valid_i && full1 && !cmp;
  assign drop2 = (state == RUN) && obs_2_valid_i && full2 && !cmp;

  assign done_o = (state == DONE);

  always_comb begin
    state_nxt = state;
    len_set   = 1'b0;
    unique case (state)
      RUN: begin
        if (finished_i) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (empty1 || empty2) begin
          state_nxt = DONE;
          len_set   = !empty1 || !empty2;
        end
      end
      DONE: state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (push1) mem1[wr1] <= obs_1_data_i;
    if (push2) mem2[wr2] <= obs_2_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd1              <= '0;
      wr1              <= '0;
      rd2              <= '0;
      wr2              <= '0;
      cnt1             <= '0;
      cnt2             <= '0;
      mismatch_o       <= 1'b0;
      mismatch_index_o <= '0;
      len_mismatch_o   <= 1'b0;
      overflow_o       <= 1'b0;
      pair_count_o     <= '0;
    end else begin
      wr1  <= wr1 + AW'(push1);
      wr2  <= wr2 + AW'(push2);
      rd1  <= rd1 + AW'(cmp);
      rd2  <= rd2 + AW'(cmp);
      cnt1 <= cnt1 + (AW+1)'(push1) - (AW+1)'(cmp);
      cnt2 <= cnt2 + (AW+1)'(push2) - (AW+1)'(cmp);
      if (cmp && (pair_count_o != '1))
        pair_count_o <= pair_count_o + 32'd1;
      if (cmp && !mismatch_o && (mem1[rd1] != mem2[rd2])) begin
        mismatch_o       <= 1'b1;
        mismatch_index_o <= pair_count_o;
      end
      if (drop1 || drop2) overflow_o     <= 1'b1;
      if (len_set)        len_mismatch_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obs_compare.sv
// Bench for obs_compare: directed trace scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_obs_compare;

  localparam int DW = 64;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v1 = 1'b0, v2 = 1'b0, fin = 1'b0;
  logic [DW-1:0] d1 = '0, d2 = '0;
  logic          done, mis, lenm, ovf;
  logic [31:0]   midx, pairs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  obs_compare #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk_i(clk), .rst_i(rst),
    .obs_1_valid_i(v1), .obs_1_data_i(d1),
    .obs_2_valid_i(v2), .obs_2_data_i(d2),
    .finished_i(fin), .done_o(done),
    .mismatch_o(mis), .mismatch_index_o(midx),
    .len_mismatch_o(lenm), .overflow_o(ovf),
    .pair_count_o(pairs)
  );

  // reference model: phase 0=running, 1=draining, 2=finished
  logic [DW-1:0] q1[$], q2[$];
  int          m_phase;
  logic [31:0] m_pairs, m_idx;
  logic        m_mis, m_len, m_ovf;

  task automatic model_step();
    int s1, s2;
    logic [DW-1:0] a, b;
    if (rst) begin
      q1.delete(); q2.delete();
      m_phase = 0; m_pairs = 0; m_idx = 0;
      m_mis = 0; m_len = 0; m_ovf = 0;
      return;
    end
    s1 = q1.size(); s2 = q2.size();
    if (m_phase != 2 && s1 > 0 && s2 > 0) begin
      a = q1.pop_front(); b = q2.pop_front();
      if (a != b && !m_mis) begin m_mis = 1; m_idx = m_pairs; end
      if (m_pairs != 32'hFFFF_FFFF) m_pairs = m_pairs + 1;
    end
    if (m_phase == 0) begin
      if (v1) begin
        if (q1.size() < DP) q1.push_back(d1); else m_ovf = 1;
      end
      if (v2) begin
        if (q2.size() < DP) q2.push_back(d2); else m_ovf = 1;
      end
      if (fin) m_phase = 1;
    end else if (m_phase == 1 && (s1 == 0 || s2 == 0)) begin
      m_phase = 2;
      if (s1 != 0 || s2 != 0) m_len = 1;
    end
  endtask

  task automatic cyc(input logic a_v, input logic [DW-1:0] a_d,
                     input logic b_v, input logic [DW-1:0] b_d,
                     input logic f);
    v1 = a_v; d1 = a_d; v2 = b_v; d2 = b_d; fin = f;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    cyc(1, 64'hdead, 1, 64'hbeef, 1);
    rst = 0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 60 && !done; i++) cyc(0, 0, 0, 0, 1);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout: done=%b required 1", nm, done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({done, mis, lenm, ovf} !== 4'b0 || pairs !== 0 || midx !== 0) begin
      bad++;
      $display("FAIL reset: flags=%b pairs=%0d idx=%0d required 0",
               {done, mis, lenm, ovf}, pairs, midx);
    end
  endtask

  task automatic test_identical();
    do_reset();
    for (int i = 1; i <= 10; i++) cyc(1, 64'(i), 1, 64'(i), 0);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL ident_run_done: got %b required 0", done);
    end
    wait_done("ident");
    total++;
    if (pairs !== 10 || {mis, lenm, ovf} !== 3'b0) begin
      bad++;
      $display("FAIL ident: pairs=%0d flags=%b required 10 000",
               pairs, {mis, lenm, ovf});
    end
  endtask

  task automatic test_skew();
    do_reset();
    for (int i = 0; i < 13; i++)
      cyc(i < 8, 64'(i + 1), i >= 5, 64'(i - 4), 0);
    wait_done("skew");
    total++;
    if (pairs !== 8 || mis !== 0 || ovf !== 0) begin
      bad++;
      $display("FAIL skew: pairs=%0d mis=%b ovf=%b required 8 0 0",
               pairs, mis, ovf);
    end
  endtask

  task automatic test_mismatch();
    logic [DW-1:0] w;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      w = 64'(100 + i);
      cyc(1, w, 1, (i == 3) ? (w ^ 64'd1) : (i == 5) ? ~w : w, 0);
    end
    wait_done("mism");
    total++;
    if (mis !== 1 || midx !== 3 || pairs !== 6) begin
      bad++;
      $display("FAIL mism: mis=%b idx=%0d pairs=%0d required 1 3 6",
               mis, midx, pairs);
    end
  endtask

  task automatic test_len();
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 64'(i), i < 4, 64'(i), 0);
    wait_done("len");
    total++;
    if (pairs !== 4 || lenm !== 1 || mis !== 0) begin
      bad++;
      $display("FAIL len: pairs=%0d len=%b mis=%b required 4 1 0",
               pairs, lenm, mis);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 64'(i), 0, 0, 0);
    total++;
    if (ovf !== 0) begin
      bad++; $display("FAIL ovf_16: got %b required 0", ovf);
    end
    cyc(1, 64'd16, 0, 0, 0);
    total++;
    if (ovf !== 1 || pairs !== 0) begin
      bad++;
      $display("FAIL ovf_17: ovf=%b pairs=%0d required 1 0", ovf, pairs);
    end
  endtask

  task automatic test_reset_drain();
    do_reset();
    cyc(1, 64'd7, 0, 0, 0);
    cyc(1, 64'd8, 1, 64'd7, 1);
    total++;
    if (done !== 0) begin
      bad++; $display("FAIL rdrain_pre: done=%b required 0", done);
    end
    do_reset();
    total++;
    if ({done, mis, lenm, ovf} !== 4'b0 || pairs !== 0 || midx !== 0) begin
      bad++;
      $display("FAIL rdrain_rst: flags=%b pairs=%0d required 0",
               {done, mis, lenm, ovf}, pairs);
    end
    cyc(1, 64'd1, 1, 64'd1, 0);
    cyc(1, 64'd2, 1, 64'd2, 0);
    wait_done("rdrain");
    total++;
    if (pairs !== 2 || {mis, lenm, ovf} !== 3'b0) begin
      bad++;
      $display("FAIL rdrain_run: pairs=%0d flags=%b required 2 000",
               pairs, {mis, lenm, ovf});
    end
  endtask

  task automatic test_random();
    int unsigned s1, s2, p1, p2, len;
    logic a, b;
    for (int r = 0; r < 8; r++) begin
      do_reset();
      s1 = 0; s2 = 0;
      p1 = $urandom_range(30, 95);
      p2 = $urandom_range(30, 95);
      len = $urandom_range(20, 70);
      for (int c = 0; c < len + 40; c++) begin
        a = ($urandom_range(99) < p1);
        b = ($urandom_range(99) < p2);
        rst = ($urandom_range(199) == 0);
        cyc(a, 64'(s1) ^ (($urandom_range(31) == 0) ? 64'd1 : 64'd0),
            b, 64'(s2), c >= len);
        if (a) s1++;
        if (b) s2++;
        rst = 0;
        total++;
        if (done !== (m_phase == 2) || mis !== m_mis || midx !== m_idx ||
            lenm !== m_len || ovf !== m_ovf || pairs !== m_pairs) begin
          bad++;
          $display("FAIL rand r%0d c%0d: d%b m%b i%0d l%b o%b p%0d required d%b m%b i%0d l%b o%b p%0d",
                   r, c, done, mis, midx, lenm, ovf, pairs,
                   m_phase == 2, m_mis, m_idx, m_len, m_ovf, m_pairs);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identical();
    test_skew();
    test_mismatch();
    test_len();
    test_overflow();
    test_reset_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
